// File: rtl/pulse_interval_meter.sv
// Slow-domain pulse event meter: detects rising edges of a synchronized strobe, measures the
// clk2 gap to the previous event and queues {first, sat, gap} records behind valid/ready.
module pulse_interval_meter #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk2,
    input  logic                     rst,
    input  logic                     pulse_in,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [CNT_W-1:0]         ev_gap,
    output logic                     ev_first,
    output logic                     ev_sat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = CNT_W + 2;
    localparam logic [CNT_W-1:0] GapMax = '1;

    logic              pulse_d_q;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic              first_q, first_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [RW-1:0]     mem_q [DEPTH];

    logic              ev_det;
    logic              full;
    logic              pop;
    logic              push;
    logic [RW-1:0]     rec;

    always_comb begin
        ev_det = pulse_in & ~pulse_d_q;
        full   = (level_q == LW'(DEPTH));
        pop    = (level_q != '0) & ev_ready;
        // A full FIFO still accepts the push when the head leaves on the same edge.
        push   = ev_det & (~full | pop);
        rec    = {first_q, (gap_q == GapMax), gap_q};

        gap_d   = gap_q;
        first_d = first_q;
        ovf_d   = ovf_q | (ev_det & full & ~pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;

        if (ev_det) begin
            gap_d   = CNT_W'(1);
            first_d = 1'b0;
        end else if (gap_q != GapMax) begin
            gap_d = gap_q + 1'b1;
        end

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            pulse_d_q <= 1'b0;
            gap_q     <= '0;
            first_q   <= 1'b1;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pulse_d_q <= pulse_in;
            gap_q     <= gap_d;
            first_q   <= first_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only observed through level/ev_valid.
    always_ff @(posedge clk2) begin
        if (!rst && push) begin
            mem_q[wptr_q] <= rec;
        end
    end

    always_comb begin
        ev_valid = (level_q != '0);
        ev_gap   = mem_q[rptr_q][CNT_W-1:0];
        ev_sat   = mem_q[rptr_q][CNT_W];
        ev_first = mem_q[rptr_q][CNT_W+1];
        level    = level_q;
        ovf      = ovf_q;
    end

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Directed bench for pulse_interval_meter (CNT_W=4, DEPTH=4) with hand-computed expectations.
module tb_pulse_interval_meter;

    logic       clk2;
    logic       rst;
    logic       pulse_in;
    logic       ev_valid;
    logic       ev_ready;
    logic [3:0] ev_gap;
    logic       ev_first;
    logic       ev_sat;
    logic [2:0] level;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    pulse_interval_meter #(
        .CNT_W(4),
        .DEPTH(4)
    ) dut (
        .clk2     (clk2),
        .rst      (rst),
        .pulse_in (pulse_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_gap   (ev_gap),
        .ev_first (ev_first),
        .ev_sat   (ev_sat),
        .level    (level),
        .ovf      (ovf)
    );

    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // After tick, cyc is the post-reset index of the next edge.
    task automatic tick();
        @(posedge clk2);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pulse_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_head(input string tag, input int gap, input bit first, input bit sat);
        chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
        chk({tag, "_gap"},   32'(ev_gap),   32'(gap));
        chk({tag, "_first"}, 32'(ev_first), 32'(first));
        chk({tag, "_sat"},   32'(ev_sat),   32'(sat));
    endtask

    initial begin
        // Reset held with pulse_in high.
        rst      = 1'b1;
        pulse_in = 1'b1;
        ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", 32'(ev_valid), 32'd0);
            chk("rst_level", 32'(level), 32'd0);
            chk("rst_ovf", 32'(ovf), 32'd0);
        end
        rst = 1'b0;
        cyc = 0;
        tick();
        chk_head("rst_ev", 0, 1'b1, 1'b0);
        chk("rst_ev_level", 32'(level), 32'd1);
        tick();
        chk("rst_held_level", 32'(level), 32'd1);
        ev_ready = 1'b1;
        tick();
        chk("rst_drain_valid", 32'(ev_valid), 32'd0);
        pulse_in = 1'b0;

        // Basic gaps: pulses at 3, 10, 12.
        do_reset();
        run_to(3);
        chk("basic_pre_valid", 32'(ev_valid), 32'd0);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk_head("basic0", 3, 1'b1, 1'b0);
        run_to(10);
        chk("basic_gap_valid", 32'(ev_valid), 32'd0);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk_head("basic1", 7, 1'b0, 1'b0);
        run_to(12);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk_head("basic2", 2, 1'b0, 1'b0);

        // Stretched pulse 5..8, then a pulse at 15.
        do_reset();
        run_to(5);
        pulse_in = 1'b1;
        run_to(6);
        chk_head("stretch0", 5, 1'b1, 1'b0);
        run_to(9);
        pulse_in = 1'b0;
        chk("stretch_level", 32'(level), 32'd0);
        run_to(15);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk_head("stretch1", 10, 1'b0, 1'b0);

        // Overflow: five pulses at 2,4,6,8,10 with no ready.
        ev_ready = 1'b0;
        do_reset();
        for (int p = 2; p <= 10; p += 2) begin
            run_to(p);
            pulse_in = 1'b1; tick(); pulse_in = 1'b0;
            if (p == 8) chk("ovf_pre", 32'(ovf), 32'd0);
        end
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk_head("ovf_h0", 2, 1'b1, 1'b0);
        ev_ready = 1'b1;
        tick();
        chk_head("ovf_h1", 2, 1'b0, 1'b0);
        chk("ovf_l1", 32'(level), 32'd3);
        tick();
        chk_head("ovf_h2", 2, 1'b0, 1'b0);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk_head("ovf_h3", 2, 1'b0, 1'b0);
        chk("ovf_l3", 32'(level), 32'd2);
        tick();
        chk_head("ovf_after", 3, 1'b0, 1'b0);
        tick();
        chk("ovf_empty", 32'(level), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // Full plus simultaneous push and pop.
        ev_ready = 1'b0;
        do_reset();
        for (int p = 2; p <= 8; p += 2) begin
            run_to(p);
            pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        end
        chk("pp_full", 32'(level), 32'd4);
        run_to(11);
        pulse_in = 1'b1;
        ev_ready = 1'b1;
        tick();
        pulse_in = 1'b0;
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_ovf", 32'(ovf), 32'd0);
        chk_head("pp_h1", 2, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk_head("pp_new", 3, 1'b0, 1'b0);
        chk("pp_l_new", 32'(level), 32'd1);

        // Saturation with a 4-bit counter.
        do_reset();
        run_to(2);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk_head("sat0", 2, 1'b1, 1'b0);
        run_to(22);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk_head("sat1", 15, 1'b0, 1'b1);
        run_to(25);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk_head("sat2", 3, 1'b0, 1'b0);

        // Reset with three records queued.
        ev_ready = 1'b0;
        do_reset();
        for (int p = 1; p <= 5; p += 2) begin
            run_to(p);
            pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        end
        chk("mid_level", 32'(level), 32'd3);
        rst = 1'b1;
        tick();
        chk("mid_valid", 32'(ev_valid), 32'd0);
        chk("mid_level0", 32'(level), 32'd0);
        rst = 1'b0;
        cyc = 0;
        run_to(2);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        chk_head("mid_ev", 2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
